// File: rtl/axi_stream_input.sv
// AXI4-Stream slave: packs DATA_WIDTH beats into SRAM_WIDTH words and writes them to the input SRAM.
// Optional tlast checking (rx_error port) is enabled by defining AXIS_IN_TLAST_CHECK_EN.
module axi_stream_input #(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 8,
  parameter int SRAM_WIDTH         = 64,
  parameter int MAX_ADDR_WIDTH     = 18,
  parameter int NUM_CHANNELS_WIDTH = $clog2(64 + 1)
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
  output logic                          sram_in_en,
  output logic [ADDR_WIDTH-1:0]         sram_in_addr,
  output logic [SRAM_WIDTH-1:0]         sram_in_data_in,
  input  logic                          start_input,
  input  logic [MAX_ADDR_WIDTH-1:0]     in_size,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  output logic                          busy,
  output logic                          input_done,
`ifdef AXIS_IN_TLAST_CHECK_EN
  output logic                          rx_error,
`endif
  output logic [NUM_CHANNELS_WIDTH-1:0] num_channels
);

  localparam int PACK   = SRAM_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  state_t                          r_state, w_next_state;
  logic                            r_tready, r_busy, r_done, r_wr_en;
  logic [ADDR_WIDTH-1:0]           r_wr_addr, r_addr;
  logic [SRAM_WIDTH-1:0]           r_wr_data, r_pack, w_pack;
  logic [MAX_ADDR_WIDTH-1:0]       r_size, r_beat_cnt;
  logic [LANE_W-1:0]               r_lane;
  logic [NUM_CHANNELS_WIDTH-1:0]   r_num_ch;
  logic                            w_start, w_hs, w_cnt_last, w_final, w_flush;

  assign w_start    = (r_state == S_IDLE) && start_input;
  assign w_hs       = (r_state == S_RECV) && r_tready && s_axis_tvalid;
  assign w_cnt_last = (r_beat_cnt == r_size - 1'b1);
  assign w_flush    = (r_lane == LANE_W'(PACK - 1)) || w_final;

`ifdef AXIS_IN_TLAST_CHECK_EN
  logic r_rx_error;

  assign w_final  = w_cnt_last || s_axis_tlast;
  assign rx_error = r_rx_error;

  // Flags both an early tlast and a missing tlast on the counted last beat.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_rx_error <= 1'b0;
    end else if (w_start) begin
      r_rx_error <= 1'b0;
    end else if (w_hs && (s_axis_tlast != w_cnt_last)) begin
      r_rx_error <= 1'b1;
    end
  end
`else
  logic w_unused_tlast;

  assign w_final        = w_cnt_last;
  assign w_unused_tlast = s_axis_tlast;
`endif

  // Current beat merged into the pack register; the register is cleared after
  // every write, so a partial final word is zero-padded automatically.
  always_comb begin
    w_pack = r_pack;
    w_pack[int'(r_lane) * DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_input) w_next_state = (in_size == '0) ? S_DONE : S_RECV;
      S_RECV:  if (w_hs && w_final) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_tready   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_addr     <= '0;
      r_pack     <= '0;
      r_size     <= '0;
      r_beat_cnt <= '0;
      r_lane     <= '0;
      r_num_ch   <= '0;
    end else begin
      r_tready <= (w_next_state == S_RECV);
      r_busy   <= (w_next_state != S_IDLE);
      r_done   <= (w_next_state == S_DONE);
      r_wr_en  <= 1'b0;
      if (w_start) begin
        r_size     <= in_size;
        r_addr     <= base_addr;
        r_lane     <= '0;
        r_beat_cnt <= '0;
        r_pack     <= '0;
      end else if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (r_beat_cnt == '0) r_num_ch <= s_axis_tuser;
        if (w_flush) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= w_pack;
          r_addr    <= r_addr + 1'b1;
          r_pack    <= '0;
          r_lane    <= '0;
        end else begin
          r_pack <= w_pack;
          r_lane <= r_lane + 1'b1;
        end
      end
    end
  end

  assign s_axis_tready   = r_tready;
  assign sram_in_en      = r_wr_en;
  assign sram_in_addr    = r_wr_addr;
  assign sram_in_data_in = r_wr_data;
  assign busy            = r_busy;
  assign input_done      = r_done;
  assign num_channels    = r_num_ch;

endmodule

// File: tb/tb_axi_stream_input.sv
// Randomized self-checking bench for axi_stream_input against a word-level packing model.
module tb_axi_stream_input;
  localparam int AW = 13, DW = 8, SW = 64, MW = 18, CW = 7, PACK = SW / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [CW-1:0] s_axis_tuser = '0;
  logic          sram_in_en, start_input = 1'b0, busy, input_done;
  logic [AW-1:0] sram_in_addr, base_addr = '0;
  logic [SW-1:0] sram_in_data_in;
  logic [MW-1:0] in_size = '0;
  logic [CW-1:0] num_channels;
`ifdef AXIS_IN_TLAST_CHECK_EN
  logic          rx_error;
`endif

  axi_stream_input #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_WIDTH(SW),
    .MAX_ADDR_WIDTH(MW), .NUM_CHANNELS_WIDTH(CW)
  ) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .sram_in_en(sram_in_en),
    .sram_in_addr(sram_in_addr), .sram_in_data_in(sram_in_data_in),
    .start_input(start_input), .in_size(in_size), .base_addr(base_addr),
    .busy(busy), .input_done(input_done),
`ifdef AXIS_IN_TLAST_CHECK_EN
    .rx_error(rx_error),
`endif
    .num_channels(num_channels)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [AW-1:0] got_addr[$];
  logic [SW-1:0] got_data[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // dmode: 0 = 0,1,2..  1 = AA,BB,CC..  2 = random.  gap < 0 toggles tvalid.
  task automatic run_xfer(input string name, input logic [AW-1:0] base, input int size,
                          input int dmode, input int gap, input bit restart,
                          input int abort_after, input int tlast_at);
    logic [DW-1:0] beats[$];
    logic [AW-1:0] exp_addr[$];
    logic [SW-1:0] exp_data[$];
    logic [SW-1:0] word;
    logic [CW-1:0] tu0;
    int eff, words, idx, cyc, done_cnt, done_cyc, last_wr_cyc, busy_bad, tready_bad;
    bit hs_pend;

    got_addr.delete();
    got_data.delete();
    for (int i = 0; i < size; i++) begin
      case (dmode)
        0:       beats.push_back(DW'(i));
        1:       beats.push_back(DW'(8'hAA + 8'h11 * i));
        default: beats.push_back(DW'($urandom));
      endcase
    end
    eff = size;
`ifdef AXIS_IN_TLAST_CHECK_EN
    if (tlast_at >= 0 && tlast_at < size - 1) eff = tlast_at + 1;
`endif
    words = (eff + PACK - 1) / PACK;
    for (int w = 0; w < words; w++) begin
      word = '0;
      for (int k = 0; k < PACK; k++)
        if (w * PACK + k < eff) word = word | (SW'(beats[w * PACK + k]) << (k * DW));
      exp_addr.push_back(AW'(int'(base) + w));
      exp_data.push_back(word);
    end
    tu0 = CW'($urandom_range(8, 64));

    @(negedge clk);
    start_input = 1'b1;
    in_size     = MW'(size);
    base_addr   = base;
    @(negedge clk);
    start_input = 1'b0;
    in_size     = MW'($urandom);
    base_addr   = AW'($urandom);
    idx = 0; hs_pend = 0; cyc = 1; done_cnt = 0; done_cyc = -1;
    last_wr_cyc = -1; busy_bad = 0; tready_bad = 0;

    while (cyc < 2000) begin
      if (hs_pend) idx++;
      if (sram_in_en) begin
        got_addr.push_back(sram_in_addr);
        got_data.push_back(sram_in_data_in);
        last_wr_cyc = cyc;
      end
      if (!busy) busy_bad++;
      if (input_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (s_axis_tready) tready_bad++;
        break;
      end
      if (abort_after >= 0 && idx == abort_after) begin
        s_axis_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({name, "_rst_data"}, sram_in_data_in, '0);
        chk({name, "_rst_ctrl"}, {s_axis_tready, sram_in_en, busy, input_done, sram_in_addr, num_channels}, '0);
        chk({name, "_no_write"}, got_addr.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start_input   = restart && (idx == size / 2);
      in_size       = MW'($urandom);
      s_axis_tvalid = (idx < size) && ((gap < 0) ? (cyc % 2 == 1) : ($urandom_range(99) >= gap));
      s_axis_tdata  = (idx < size) ? beats[idx] : DW'($urandom);
      s_axis_tuser  = (idx == 0) ? tu0 : CW'(7);
      s_axis_tlast  = (idx == tlast_at);
      hs_pend       = s_axis_tvalid && s_axis_tready;
      @(negedge clk);
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    start_input   = 1'b0;

    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_nwords"}, got_addr.size(), words);
    for (int w = 0; w < words && w < got_addr.size(); w++) begin
      chk($sformatf("%s_addr%0d", name, w), got_addr[w], exp_addr[w]);
      chk($sformatf("%s_data%0d", name, w), got_data[w], exp_data[w]);
    end
    if (words > 0) chk({name, "_last_wr_with_done"}, last_wr_cyc, done_cyc);
    else           chk({name, "_done_latency"}, done_cyc, 1);
    chk({name, "_busy_held"}, busy_bad, 0);
    chk({name, "_tready_in_done"}, tready_bad, 0);
    if (size > 0) begin
      chk({name, "_beats"}, idx, eff);
      chk({name, "_num_ch"}, num_channels, tu0);
    end
`ifdef AXIS_IN_TLAST_CHECK_EN
    chk({name, "_rx_error"}, rx_error, (size > 0) && (tlast_at != size - 1));
`endif
    @(negedge clk);
    chk({name, "_idle"}, {busy, input_done, s_axis_tready, sram_in_en}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    repeat (3) @(negedge clk);
    chk("reset_data", sram_in_data_in, '0);
    chk("reset_ctrl", {s_axis_tready, sram_in_en, busy, input_done, sram_in_addr, num_channels}, '0);
    rst_n = 1'b1;

    run_xfer("basic", 13'h010, 16, 0, 0, 0, -1, 15);
    chk("basic_w0_lit", got_data[0], 64'h0706050403020100);
    chk("basic_w1_lit", got_data[1], 64'h0F0E0D0C0B0A0908);
    chk("basic_a1_lit", got_addr[1], 13'h011);

    run_xfer("partial", AW'($urandom), 3, 1, -1, 0, -1, 2);
    chk("partial_lit", got_data[0], 64'h0000000000CCBBAA);

    run_xfer("zero", AW'($urandom), 0, 2, 0, 0, -1, -1);

    run_xfer("wrap", 13'h1FFF, 16, 2, 20, 0, -1, 15);
    chk("wrap_a0_lit", got_addr[0], 13'h1FFF);
    chk("wrap_a1_lit", got_addr[1], 13'h0000);

    run_xfer("abort", 13'h040, 16, 2, 0, 0, 5, 15);
    run_xfer("post_rst", 13'h040, 8, 2, 10, 0, -1, 7);

    run_xfer("restart", 13'h080, 24, 2, 25, 1, -1, 23);

    for (int t = 0; t < 6; t++) begin
      sz = $urandom_range(1, 40);
      run_xfer($sformatf("rand%0d", t), AW'($urandom), sz, 2, 30, 0, -1,
               (t % 2 == 0) ? sz - 1 : int'($urandom_range(0, 40)));
    end

`ifdef AXIS_IN_TLAST_CHECK_EN
    run_xfer("early_tlast", 13'h020, 16, 0, 0, 0, -1, 9);
    chk("early_w1_lit", got_data[1], 64'h0000000000000908);
    run_xfer("clean_after", 13'h020, 8, 0, 0, 0, -1, 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
